// File: rtl/alu32_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu32_pkg
// Description : Shared constants for the 32-bit logic issue/collect stage:
//               default widths, unit count and opcode assignments.
// Revision    : 1.0 - initial release
// ============================================================================
package alu32_pkg;

  // Default datapath geometry
  localparam int ALU_WIDTH     = 32;
  localparam int ALU_OP_W      = 3;
  localparam int ALU_NUM_UNITS = 4;
  localparam int ALU_CNT_W     = 16;

  // Opcode i enables gated unit i
  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 2;
  localparam int OP_NOR = 3;

endpackage
`default_nettype wire

// File: rtl/alu32_logic_issue_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu32_logic_issue_if
// Description : Upstream request, unit-side and downstream result signals of
//               the logic issue stage. The stage itself uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu32_logic_issue_if
  import alu32_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int OP_W      = ALU_OP_W,
  parameter int NUM_UNITS = ALU_NUM_UNITS,
  parameter int CNT_W     = ALU_CNT_W
);
  // Upstream request
  logic                 In_Valid;
  logic                 In_Ready;
  logic [OP_W-1:0]      Op;
  logic [WIDTH-1:0]     In1;
  logic [WIDTH-1:0]     In2;
  // Unit side
  logic [WIDTH-1:0]     UnitA;
  logic [WIDTH-1:0]     UnitB;
  logic [NUM_UNITS-1:0] EnVec;
  logic [WIDTH-1:0]     UnitRes;
  // Downstream result
  logic                 Out_Valid;
  logic                 Out_Ready;
  logic [WIDTH-1:0]     Out;
  logic                 Zero;
  logic                 Err;
  logic [CNT_W-1:0]     OpCount;

  modport slave (
    input  In_Valid, Op, In1, In2, UnitRes, Out_Ready,
    output In_Ready, UnitA, UnitB, EnVec, Out_Valid, Out, Zero, Err, OpCount
  );

  modport master (
    output In_Valid, Op, In1, In2, UnitRes, Out_Ready,
    input  In_Ready, UnitA, UnitB, EnVec, Out_Valid, Out, Zero, Err, OpCount
  );

endinterface
`default_nettype wire

// File: rtl/alu32_op_onehot.sv
`default_nettype none
// ============================================================================
// Module      : alu32_op_onehot
// Description : Combinational opcode decode: one-hot unit enable and an
//               illegal-opcode flag. Enables are all zero when not valid or
//               when the opcode has no matching unit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_op_onehot
  import alu32_pkg::*;
#(
  parameter int OP_W      = ALU_OP_W,
  parameter int NUM_UNITS = ALU_NUM_UNITS
) (
  input  logic [OP_W-1:0]      op,
  input  logic                 valid,
  output logic [NUM_UNITS-1:0] en_vec,
  output logic                 illegal
);

  // Opcode zero-extended to int so it compares cleanly against the unit count
  logic w_legal;

  assign illegal = (int'(op) >= NUM_UNITS);
  assign w_legal = valid && !illegal;

  // One enable per unit; a single bit at most can match the opcode
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_en
    assign en_vec[i] = w_legal && (int'(op) == i);
  end

endmodule
`default_nettype wire

// File: rtl/alu32_logic_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu32_logic_issue
// Description : Two-stage issue/collect wrapper around the gated 32-bit logic
//               units. S0 holds the operands and drives one unit enable; S1
//               captures the OR-combined unit result with Zero/Err flags and
//               presents it over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_logic_issue
  import alu32_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int OP_W      = ALU_OP_W,
  parameter int NUM_UNITS = ALU_NUM_UNITS,
  parameter int CNT_W     = ALU_CNT_W
) (
  input logic               Clk,
  input logic               Rst,
  alu32_logic_issue_if.slave bus
);

  // Issue stage
  logic                 r_s0_valid;
  logic [OP_W-1:0]      r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  // Result stage
  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_out;
  logic                 r_zero;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_s1_load;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_handoff;
  logic                 w_illegal;
  logic [NUM_UNITS-1:0] w_en_vec;
  logic [WIDTH-1:0]     w_res;

  alu32_op_onehot #(
    .OP_W      (OP_W),
    .NUM_UNITS (NUM_UNITS)
  ) u_onehot (
    .op      (r_op),
    .valid   (r_s0_valid),
    .en_vec  (w_en_vec),
    .illegal (w_illegal)
  );

  // S0 may advance whenever S1 is free or being drained this cycle.
  // In_Ready is held low during reset so nothing is offered as accepted.
  assign w_s1_load  = r_s0_valid && (!r_s1_valid || bus.Out_Ready);
  assign w_in_ready = !Rst && (!r_s0_valid || w_s1_load);
  assign w_accept   = bus.In_Valid && w_in_ready;
  assign w_handoff  = r_s1_valid && bus.Out_Ready;
  // Illegal opcodes enable no unit; force the result to zero regardless
  assign w_res      = w_illegal ? '0 : bus.UnitRes;

  // Issue register: load on accept, empty when advanced without a refill
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s0_valid <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (w_accept) begin
      r_s0_valid <= 1'b1;
      r_op       <= bus.Op;
      r_a        <= bus.In1;
      r_b        <= bus.In2;
    end else if (w_s1_load) begin
      r_s0_valid <= 1'b0;
    end
  end

  // Result register: capture unit return on advance, empty after handoff
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1_valid <= 1'b0;
      r_out      <= '0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_out      <= w_res;
      r_zero     <= (w_res == '0);
      r_err      <= w_illegal;
    end else if (w_handoff) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Handoff counter, wraps naturally at full scale
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (w_handoff) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.UnitA     = r_a;
  assign bus.UnitB     = r_b;
  assign bus.EnVec     = w_en_vec;
  assign bus.Out_Valid = r_s1_valid;
  assign bus.Out       = r_out;
  assign bus.Zero      = r_zero;
  assign bus.Err       = r_err;
  assign bus.OpCount   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu32_logic_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu32_logic_issue
// Description : Self-checking bench for the logic issue stage, including a
//               model of the gated AND/OR/XOR/NOR units on the unit side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu32_logic_issue;
  import alu32_pkg::*;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  exp_t q[$];

  int          cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;

  alu32_logic_issue_if bus ();

  alu32_logic_issue dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Gated logic units: a disabled unit contributes zero to the OR return
  always_comb begin
    bus.UnitRes = '0;
    if (bus.EnVec[0]) bus.UnitRes = bus.UnitRes | (bus.UnitA & bus.UnitB);
    if (bus.EnVec[1]) bus.UnitRes = bus.UnitRes | (bus.UnitA | bus.UnitB);
    if (bus.EnVec[2]) bus.UnitRes = bus.UnitRes | (bus.UnitA ^ bus.UnitB);
    if (bus.EnVec[3]) bus.UnitRes = bus.UnitRes | ~(bus.UnitA | bus.UnitB);
  end

  function automatic exp_t model(int op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    case (op)
      OP_AND:  e.out = a & b;
      OP_OR:   e.out = a | b;
      OP_XOR:  e.out = a ^ b;
      OP_NOR:  e.out = ~(a | b);
      default: e.out = 32'h0;
    endcase
    e.err  = (op >= 4);
    e.zero = (e.out == 32'h0);
    return e;
  endfunction

  function automatic logic [31:0] en_model(int op);
    return (op < 4) ? (32'd1 << op) : 32'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic timeout(string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic set_in(int op, logic [31:0] a, logic [31:0] b);
    cur_op  = op;
    cur_a   = a;
    cur_b   = b;
    bus.Op  = 3'(op);
    bus.In1 = a;
    bus.In2 = b;
  endtask

  task automatic set_rand();
    set_in(int'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Present one request and wait (bounded) for it to be accepted
  task automatic send(int op, logic [31:0] a, logic [31:0] b);
    set_in(op, a, b);
    bus.In_Valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.In_Ready) begin
        q.push_back(model(op, a, b));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    timeout("send_accept");
  endtask

  // Single op with its stage-by-stage timing checked
  task automatic single(string tag, int op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    send(op, a, b);
    bus.In_Valid = 1'b0;
    @(negedge clk);
    chk({tag, "_envec"}, 32'(bus.EnVec), en_model(op));
    chk({tag, "_unit_a"}, bus.UnitA, a);
    chk({tag, "_unit_b"}, bus.UnitB, b);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(bus.Out_Valid), 32'd1);
    chk({tag, "_out"}, bus.Out, e.out);
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(e.zero));
    chk({tag, "_err"}, 32'(bus.Err), 32'(e.err));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.Out_Valid) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    timeout("drain");
  endtask

  // Scoreboard: every handoff must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.Out_Valid && bus.Out_Ready) begin
      chk("result_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_out", bus.Out, e.out);
        chk("sb_zero", 32'(bus.Zero), 32'(e.zero));
        chk("sb_err", 32'(bus.Err), 32'(e.err));
      end
      chk("sb_opcount", 32'(bus.OpCount), 32'(exp_cnt));
      exp_cnt = (exp_cnt + 1) % 65536;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int acc;
    int n;
    int bp_op[4];
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];

    // ---- reset held with a request pending ----
    bus.Out_Ready = 1'b1;
    bus.In_Valid  = 1'b1;
    set_in(1, 32'hFFFF_FFFF, 32'h1234_5678);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
      chk("rst_in_ready", 32'(bus.In_Ready), 32'd0);
      chk("rst_envec", 32'(bus.EnVec), 32'd0);
      chk("rst_out", bus.Out, 32'd0);
      chk("rst_unit_a", bus.UnitA, 32'd0);
      chk("rst_opcount", 32'(bus.OpCount), 32'd0);
      chk("rst_flags", {30'd0, bus.Zero, bus.Err}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.In_Valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.In_Ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.Out_Valid), 32'd0);
    @(posedge clk); #1;

    // ---- directed single ops ----
    single("xor", 2, 32'hF0F0_1234, 32'h0F0F_1234);
    chk("xor_known_value", model(2, 32'hF0F0_1234, 32'h0F0F_1234).out, 32'hFFFF_0000);
    single("zero", 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    single("illegal", 5, 32'hA5A5_A5A5, 32'h5A5A_0001);
    drain();
    chk("opcount_after_illegal", 32'(bus.OpCount), 32'd3);

    // ---- backpressure: ops 0..3, Out_Ready low for 4 cycles ----
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = i;
      bp_a[i]  = $urandom;
      bp_b[i]  = $urandom;
    end
    bus.Out_Ready = 1'b0;
    idx = 0;
    set_in(bp_op[0], bp_a[0], bp_b[0]);
    bus.In_Valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("bp_in_ready", 32'(bus.In_Ready), 32'd0);
        chk("bp_out_valid", 32'(bus.Out_Valid), 32'd1);
        chk("bp_out_held", bus.Out, model(bp_op[0], bp_a[0], bp_b[0]).out);
        chk("bp_envec", 32'(bus.EnVec), en_model(bp_op[1]));
      end
      if (bus.In_Ready && idx < 4) begin
        q.push_back(model(bp_op[idx], bp_a[idx], bp_b[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) set_in(bp_op[idx], bp_a[idx], bp_b[idx]);
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    bus.Out_Ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.In_Ready) begin
        q.push_back(model(bp_op[idx], bp_a[idx], bp_b[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) set_in(bp_op[idx], bp_a[idx], bp_b[idx]);
    end
    bus.In_Valid = 1'b0;
    if (idx != 4) timeout("bp_release");
    drain();
    chk("bp_opcount", 32'(bus.OpCount), 32'd7);

    // ---- throughput: 100 random ops, one per cycle ----
    bus.Out_Ready = 1'b1;
    set_rand();
    bus.In_Valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("tp_in_ready", 32'(bus.In_Ready), 32'd1);
      if (c >= 2) chk("tp_out_valid", 32'(bus.Out_Valid), 32'd1);
      if (bus.In_Ready) q.push_back(model(cur_op, cur_a, cur_b));
      @(posedge clk); #1;
      set_rand();
    end
    bus.In_Valid = 1'b0;
    drain();
    chk("tp_opcount", 32'(bus.OpCount), 32'd107);

    // ---- counter wrap ----
    n = 65535 - exp_cnt;
    acc = 0;
    set_rand();
    bus.In_Valid = 1'b1;
    for (int c = 0; c < n + 100 && acc < n; c++) begin
      @(negedge clk);
      if (bus.In_Ready) begin
        q.push_back(model(cur_op, cur_a, cur_b));
        acc++;
      end
      @(posedge clk); #1;
      set_rand();
    end
    bus.In_Valid = 1'b0;
    if (acc != n) timeout("wrap_fill");
    drain();
    chk("opcount_ffff", 32'(bus.OpCount), 32'h0000_FFFF);
    single("wrap", int'($urandom_range(0, 3)), $urandom, $urandom);
    drain();
    chk("opcount_wrap", 32'(bus.OpCount), 32'd0);

    // ---- reset with both stages full ----
    bus.Out_Ready = 1'b0;
    send(0, 32'h1111_2222, 32'h3333_4444);
    send(1, 32'h5555_6666, 32'h7777_8888);
    bus.In_Valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 32'(bus.In_Ready), 32'd0);
    chk("full_out_valid", 32'(bus.Out_Valid), 32'd1);
    chk("full_envec", 32'(bus.EnVec), en_model(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.Out_Valid), 32'd0);
    chk("midrst_envec", 32'(bus.EnVec), 32'd0);
    chk("midrst_out", bus.Out, 32'd0);
    chk("midrst_opcount", 32'(bus.OpCount), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_out_valid", 32'(bus.Out_Valid), 32'd0);
      chk("after_rst_in_ready", 32'(bus.In_Ready), 32'd1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
